// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, forwarding selects and counter helper for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } state_e;

  localparam logic [1:0]  FWD_REG = 2'b00;
  localparam logic [1:0]  FWD_WB  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one ALU source; the nearer MEM stage wins over WB.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       exmem_regwrite_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_regwrite_i,
  input  logic [4:0] memwb_rd_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_REG;
    if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs_i))
      fwd_o = FWD_MEM;
    else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_i))
      fwd_o = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: memory-wait freeze, branch flush, load-use bubble,
// operand forwarding and saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IFID_rs1_i,
  input  logic [4:0]  IFID_rs2_i,
  input  logic        IFID_use_rs2_i,
  input  logic        IDEX_memread_i,
  input  logic [4:0]  IDEX_rd_i,
  input  logic [4:0]  IDEX_rs1_i,
  input  logic [4:0]  IDEX_rs2_i,
  input  logic        EXMEM_regwrite_i,
  input  logic [4:0]  EXMEM_rd_i,
  input  logic        MEMWB_regwrite_i,
  input  logic [4:0]  MEMWB_rd_i,
  input  logic        branch_taken_i,
  input  logic        dmem_busy_i,
  input  logic        clr_cnt_i,
  output logic        pc_we_o,
  output logic        IFID_we_o,
  output logic        IFID_flush_o,
  output logic        IDEX_flush_o,
  output logic        EXMEM_flush_o,
  output logic [1:0]  fwdA_o,
  output logic [1:0]  fwdB_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;
  logic        pc_we, ifid_we, ifid_fl, idex_fl, exmem_fl, br_flush;
  logic [1:0]  fwd_a, fwd_b;

  assign load_use = IDEX_memread_i && (IDEX_rd_i != 5'd0) &&
                    ((IDEX_rd_i == IFID_rs1_i) || (IFID_use_rs2_i && (IDEX_rd_i == IFID_rs2_i)));

  // Event priority: memory wait, then taken branch, then load-use (masked in LDSTALL).
  always_comb begin
    state_d  = RUN;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    br_flush = 1'b0;
    case (state_q)
      RUN, LDSTALL, FREEZE: begin
        if (dmem_busy_i) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          state_d = FREEZE;
        end else if (branch_taken_i) begin
          ifid_fl  = 1'b1;
          idex_fl  = 1'b1;
          exmem_fl = 1'b1;
          br_flush = 1'b1;
        end else if ((state_q != LDSTALL) && load_use) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_fl = 1'b1;
          state_d = LDSTALL;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (!pc_we)   stall_cnt_d = sat_inc(stall_cnt_q);
      if (br_flush) flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pipe_fwd_unit u_fwd_a (
    .rs_i             (IDEX_rs1_i),
    .exmem_regwrite_i (EXMEM_regwrite_i),
    .exmem_rd_i       (EXMEM_rd_i),
    .memwb_regwrite_i (MEMWB_regwrite_i),
    .memwb_rd_i       (MEMWB_rd_i),
    .fwd_o            (fwd_a)
  );

  pipe_fwd_unit u_fwd_b (
    .rs_i             (IDEX_rs2_i),
    .exmem_regwrite_i (EXMEM_regwrite_i),
    .exmem_rd_i       (EXMEM_rd_i),
    .memwb_regwrite_i (MEMWB_regwrite_i),
    .memwb_rd_i       (MEMWB_rd_i),
    .fwd_o            (fwd_b)
  );

  // While reset is held the pipeline is frozen with every register flushed.
  assign pc_we_o       = pc_we & ~rst_i;
  assign IFID_we_o     = ifid_we & ~rst_i;
  assign IFID_flush_o  = ifid_fl | rst_i;
  assign IDEX_flush_o  = idex_fl | rst_i;
  assign EXMEM_flush_o = exmem_fl | rst_i;
  assign fwdA_o        = rst_i ? FWD_REG : fwd_a;
  assign fwdB_o        = rst_i ? FWD_REG : fwd_b;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IFID_rs1, IFID_rs2, IDEX_rd, IDEX_rs1, IDEX_rs2, EXMEM_rd, MEMWB_rd;
  logic        IFID_use_rs2, IDEX_memread, EXMEM_regwrite, MEMWB_regwrite;
  logic        branch_taken, dmem_busy, clr_cnt;
  logic        pc_we_o, IFID_we_o, IFID_flush_o, IDEX_flush_o, EXMEM_flush_o;
  logic [1:0]  fwdA_o, fwdB_o, state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: state as 0=RUN 1=LDSTALL 2=FREEZE, counters as plain integers.
  int       m_state, m_stall, m_flush;
  logic     e_pc, e_ifid, e_br;
  logic [2:0] e_fl;
  int       e_next;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs1_i(IFID_rs1), .IFID_rs2_i(IFID_rs2), .IFID_use_rs2_i(IFID_use_rs2),
    .IDEX_memread_i(IDEX_memread), .IDEX_rd_i(IDEX_rd), .IDEX_rs1_i(IDEX_rs1), .IDEX_rs2_i(IDEX_rs2),
    .EXMEM_regwrite_i(EXMEM_regwrite), .EXMEM_rd_i(EXMEM_rd),
    .MEMWB_regwrite_i(MEMWB_regwrite), .MEMWB_rd_i(MEMWB_rd),
    .branch_taken_i(branch_taken), .dmem_busy_i(dmem_busy), .clr_cnt_i(clr_cnt),
    .pc_we_o(pc_we_o), .IFID_we_o(IFID_we_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_flush_o(IDEX_flush_o), .EXMEM_flush_o(EXMEM_flush_o),
    .fwdA_o(fwdA_o), .fwdB_o(fwdB_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (EXMEM_regwrite && EXMEM_rd != 0 && EXMEM_rd == rs) return 2'b10;
    if (MEMWB_regwrite && MEMWB_rd != 0 && MEMWB_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_comb();
    bit lu;
    lu = IDEX_memread && IDEX_rd != 0 &&
         (IDEX_rd == IFID_rs1 || (IFID_use_rs2 && IDEX_rd == IFID_rs2));
    e_pc = 1; e_ifid = 1; e_fl = 3'b000; e_br = 0; e_next = 0;
    if (dmem_busy) begin
      e_pc = 0; e_ifid = 0; e_next = 2;
    end else if (branch_taken) begin
      e_fl = 3'b111; e_br = 1;
    end else if (m_state != 1 && lu) begin
      e_pc = 0; e_ifid = 0; e_fl = 3'b010; e_next = 1;
    end
  endfunction

  // Entered shortly after a rising edge with inputs already applied.
  task automatic step();
    model_comb();
    #3;
    chk("pc_we", 16'(pc_we_o), 16'(e_pc));
    chk("ifid_we", 16'(IFID_we_o), 16'(e_ifid));
    chk("flushes", 16'({IFID_flush_o, IDEX_flush_o, EXMEM_flush_o}), 16'(e_fl));
    chk("fwdA", 16'(fwdA_o), 16'(fwd_model(IDEX_rs1)));
    chk("fwdB", 16'(fwdB_o), 16'(fwd_model(IDEX_rs2)));
    chk("state", 16'(state_o), 16'(m_state));
    chk("stall_cnt", stall_cnt_o, 16'(m_stall));
    chk("flush_cnt", flush_cnt_o, 16'(m_flush));
    @(posedge clk);
    if (clr_cnt) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < 65535) m_stall++;
      if (e_br && m_flush < 65535) m_flush++;
    end
    m_state = e_next;
    #1;
  endtask

  task automatic clear_inputs();
    IFID_rs1 = 0; IFID_rs2 = 0; IFID_use_rs2 = 0; IDEX_memread = 0; IDEX_rd = 0;
    IDEX_rs1 = 0; IDEX_rs2 = 0; EXMEM_regwrite = 0; EXMEM_rd = 0;
    MEMWB_regwrite = 0; MEMWB_rd = 0; branch_taken = 0; dmem_busy = 0; clr_cnt = 0;
  endtask

  task automatic clear_counters();
    clr_cnt = 1; step(); clr_cnt = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 16'(state_o), 16'd0);
    chk({tag, "_stall"}, stall_cnt_o, 16'd0);
    chk({tag, "_flcnt"}, flush_cnt_o, 16'd0);
    chk({tag, "_we"}, 16'({pc_we_o, IFID_we_o}), 16'd0);
    chk({tag, "_flushes"}, 16'({IFID_flush_o, IDEX_flush_o, EXMEM_flush_o}), 16'h7);
    chk({tag, "_fwd"}, 16'({fwdA_o, fwdB_o}), 16'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    m_state = 0; m_stall = 0; m_flush = 0;
    EXMEM_regwrite = 1; EXMEM_rd = 3; IDEX_rs1 = 3; IDEX_rs2 = 3; dmem_busy = 1;
    #2;
    chk_reset("rst0");
    #5;
    chk_reset("rst_edge");
    clear_inputs();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Load-use: one bubble, then back to RUN
    clear_counters();
    IDEX_memread = 1; IDEX_rd = 5; IFID_rs1 = 5;
    step();
    chk("lu_state_ldstall", 16'(state_o), 16'd1);
    step();
    chk("lu_state_run", 16'(state_o), 16'd0);
    chk("lu_stall_cnt", stall_cnt_o, 16'd1);
    IFID_rs1 = 0; IFID_rs2 = 5; IFID_use_rs2 = 1;
    step();
    chk("lu_rs2_state", 16'(state_o), 16'd1);
    clear_inputs();
    step();

    // Forwarding priority
    EXMEM_rd = 7; MEMWB_rd = 7; IDEX_rs1 = 7; IDEX_rs2 = 7;
    EXMEM_regwrite = 1; MEMWB_regwrite = 1;
    step();
    chk("fwdA_mem", 16'(fwdA_o), 16'h2);
    EXMEM_regwrite = 0;
    step();
    chk("fwdA_wb", 16'(fwdA_o), 16'h1);
    EXMEM_regwrite = 1; EXMEM_rd = 0; MEMWB_rd = 0; IDEX_rs1 = 0; IDEX_rs2 = 0;
    step();
    chk("fwdA_x0", 16'(fwdA_o), 16'h0);
    clear_inputs();

    // Busy outranks branch; branch flushes once busy drops
    clear_counters();
    dmem_busy = 1; branch_taken = 1;
    repeat (3) step();
    chk("frz_state", 16'(state_o), 16'd2);
    chk("frz_flcnt", flush_cnt_o, 16'd0);
    dmem_busy = 0;
    step();
    branch_taken = 0;
    chk("br_flcnt", flush_cnt_o, 16'd1);
    chk("br_state", 16'(state_o), 16'd0);

    // Stall counter saturation
    clear_counters();
    dmem_busy = 1;
    repeat (70000) @(posedge clk);
    #1;
    m_stall = 65535; m_state = 2;
    chk("sat_stall", stall_cnt_o, 16'hFFFF);
    dmem_busy = 0;
    clear_counters();
    chk("sat_clr", stall_cnt_o, 16'd0);

    // Asynchronous reset in the middle of LDSTALL
    IDEX_memread = 1; IDEX_rd = 9; IFID_rs1 = 9;
    step();
    clear_inputs();
    chk("pre_rst_state", 16'(state_o), 16'd1);
    #2;
    rst = 1;
    #1;
    chk_reset("rst_mid");
    m_state = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Randomized traffic over a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      IFID_rs1       = 5'($urandom_range(0, 3));
      IFID_rs2       = 5'($urandom_range(0, 3));
      IFID_use_rs2   = 1'($urandom_range(0, 1));
      IDEX_memread   = ($urandom_range(0, 2) == 0);
      IDEX_rd        = 5'($urandom_range(0, 3));
      IDEX_rs1       = 5'($urandom_range(0, 3));
      IDEX_rs2       = 5'($urandom_range(0, 3));
      EXMEM_regwrite = 1'($urandom_range(0, 1));
      EXMEM_rd       = 5'($urandom_range(0, 3));
      MEMWB_regwrite = 1'($urandom_range(0, 1));
      MEMWB_rd       = 5'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 7) == 0);
      dmem_busy      = ($urandom_range(0, 5) == 0);
      clr_cnt        = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
